seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle signed ALU. Supports add, subtract, multiply and divide on WIDTH-bit two's-complement operands.
- Multiply and divide are iterative, one bit per cycle, instead of combinational, so the block scales to wide operands without long combinational paths.
- Operands enter through a valid/ready request channel. Results leave through a valid/ready response channel, with status flags.
- Sits between the operand source (switch/register front-end) and the display/result consumer.

Parameters:
WIDTH, 6, operand width in bits (>= 2); result bus is 2*WIDTH
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_i  in  1  synchronous, active-high reset
in_valid_i  in  1  request valid
in_ready_o  out  1  block can accept a request
a_i  in  WIDTH  operand A, signed
b_i  in  WIDTH  operand B, signed
op_i  in  2  00 add, 01 sub, 10 mul, 11 div
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
data_o  out  2*WIDTH  result
ovf_o  out  1  signed overflow (add/sub/div)
dbz_o  out  1  divide by zero
busy_o  out  1  high in CALC or DONE

Behaviour:
- Reset (sync, rst_i high at an edge):
  - State goes to IDLE.
  - in_ready_o=1, out_valid_o=0, data_o=0, ovf_o=0, dbz_o=0, busy_o=0.
  - Counter, partial-product and remainder registers are cleared.
  - Reset mid-operation aborts the operation; no result is ever presented for it.
- States:
  - IDLE: in_ready_o=1. A request is accepted on an edge where in_valid_i & in_ready_o.
    - add/sub: result is computed and registered at the accept edge; state goes to DONE.
    - mul/div: the block latches |A|, |B|, op and the result signs, clears the counter, and goes to CALC.
  - CALC: in_ready_o=0. One iteration per cycle.
    - mul: shift-add on a 2*WIDTH accumulator.
    - div: restoring division; one quotient bit per cycle, MSB first.
    - After WIDTH iterations, apply the signs, register data_o and flags, and go to DONE.
  - DONE: out_valid_o=1; data_o and flags are held stable. Leave to IDLE on an edge where out_ready_i=1.
    - in_ready_o=0 in DONE. No new request is accepted in the same cycle as the result handshake.
- Latency from the accept edge to out_valid_o high:
  - add/sub: 1 cycle.
  - mul/div: WIDTH+1 cycles.
  - Back-pressure (out_ready_i low) stretches DONE indefinitely.
- Arithmetic and width rules:
  - add/sub: data_o = {WIDTH zeros, low WIDTH bits of the result}. ovf_o is set when the operand signs and result sign indicate signed overflow.
  - mul: data_o = full 2*WIDTH signed product; it never overflows, so ovf_o=0.
  - div: data_o = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
    - Quotient truncates toward zero; remainder takes the sign of A.
  - div with A = -2^(WIDTH-1), B = -1:
    - quotient wraps to -2^(WIDTH-1), remainder 0, ovf_o=1.
  - div with B=0:
    - quotient all ones, remainder = A, dbz_o=1, ovf_o=0.
    - The iteration is skipped; still WIDTH+1 cycles latency, so timing stays uniform.
- Flags are valid only while out_valid_o=1. They are cleared at the edge that accepts the next request.
- Inputs a_i/b_i/op_i are sampled only at the accept edge. Changes while busy are ignored.
- in_valid_i while busy: no effect. The request is held off by in_ready_o=0.

Test Plan:
- Reset, then WIDTH=6, add 31+1 -> one cycle after accept: out_valid_o=1, data_o=12'h020, ovf_o=1, dbz_o=0.
- mul -32 * -32 -> out_valid_o rises exactly 7 cycles after accept; data_o=12'h400, ovf_o=0; busy_o high throughout.
- div -7 / 2 -> data_o=12'hFFD (r=-1, q=-3); then div -32 / -1 -> data_o=12'h020, ovf_o=1.
- div 5 / 0 -> data_o=12'h17F, dbz_o=1, latency 7 cycles.
- Back-pressure: sub 3-5 with out_ready_i low for 10 cycles -> data_o=12'h03E held stable, in_ready_o=0; the result retires on the first cycle out_ready_i=1, and in_ready_o=1 on the next cycle.
- Reset mid-op: assert rst_i 3 cycles into a mul -> next cycle state is IDLE, out_valid_o=0, data_o=0; a following add 1+2 returns 12'h003.

Source files
------------

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle signed ALU (add/sub/mul/div) with valid/ready
//               request and response channels; mul/div iterate one bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [1:0]           op_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   data_o,
    output logic                 ovf_o,
    output logic                 dbz_o,
    output logic                 busy_o
);

    localparam int                c_W2        = 2 * WIDTH;
    localparam logic [WIDTH-1:0]  c_one_w     = WIDTH'(1);
    localparam logic [c_W2-1:0]   c_one_w2    = c_W2'(1);
    localparam logic [WIDTH-1:0]  c_min_w     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  c_ones_w    = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]  c_last_cnt  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic [WIDTH-1:0]    r_mag_b;
    logic [WIDTH-1:0]    r_a_raw;
    logic                r_neg_res;
    logic                r_neg_a;
    logic                r_dbz_pend;
    logic                r_ovf_pend;
    logic [c_W2-1:0]     r_acc;
    logic [c_W2-1:0]     r_data;
    logic                r_ovf;
    logic                r_dbz;

    logic                w_accept;
    logic                w_last;
    logic [WIDTH-1:0]    w_sum;
    logic [WIDTH-1:0]    w_diff;
    logic                w_add_ovf;
    logic                w_sub_ovf;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [WIDTH:0]      w_mul_add;
    logic [c_W2-1:0]     w_mul_next;
    logic [WIDTH:0]      w_div_trial;
    logic                w_div_ge;
    logic [WIDTH-1:0]    w_div_rem;
    logic [c_W2-1:0]     w_div_next;
    logic [c_W2-1:0]     w_step_next;
    logic [c_W2-1:0]     w_prod;
    logic [WIDTH-1:0]    w_quo;
    logic [WIDTH-1:0]    w_rem;
    logic [WIDTH-1:0]    w_quo_s;
    logic [WIDTH-1:0]    w_rem_s;
    logic [c_W2-1:0]     w_div_data;
    logic [c_W2-1:0]     w_final_data;

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign data_o      = r_data;
    assign ovf_o       = r_ovf;
    assign dbz_o       = r_dbz;

    assign w_accept = in_valid_i && (r_state == S_IDLE);
    assign w_last   = (r_cnt == c_last_cnt);

    assign w_sum     = a_i + b_i;
    assign w_diff    = a_i - b_i;
    assign w_add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1]  != a_i[WIDTH-1]);
    assign w_sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);

    // Magnitude of the most negative value is still correct when read unsigned.
    assign w_mag_a = a_i[WIDTH-1] ? (~a_i + c_one_w) : a_i;
    assign w_mag_b = b_i[WIDTH-1] ? (~b_i + c_one_w) : b_i;

    // Shift-add: low half holds the remaining multiplier bits, LSB first.
    assign w_mul_add  = {1'b0, r_acc[c_W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_add, r_acc[WIDTH-1:1]};

    // Restoring division: upper half is the remainder, low half shifts the
    // dividend out MSB first while quotient bits shift in at the bottom.
    assign w_div_trial = r_acc[c_W2-1:WIDTH-1] - {1'b0, r_mag_b};
    assign w_div_ge    = ~w_div_trial[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_trial[WIDTH-1:0] : r_acc[c_W2-2:WIDTH-1];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    assign w_step_next = r_is_div ? w_div_next : w_mul_next;

    assign w_prod  = r_neg_res ? (~w_mul_next + c_one_w2) : w_mul_next;
    assign w_quo   = w_div_next[WIDTH-1:0];
    assign w_rem   = w_div_next[c_W2-1:WIDTH];
    assign w_quo_s = r_neg_res ? (~w_quo + c_one_w) : w_quo;
    assign w_rem_s = r_neg_a   ? (~w_rem + c_one_w) : w_rem;

    assign w_div_data   = r_dbz_pend ? {r_a_raw, c_ones_w} : {w_rem_s, w_quo_s};
    assign w_final_data = r_is_div ? w_div_data : w_prod;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = op_i[1] ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_mag_b    <= '0;
            r_a_raw    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_a    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_acc      <= '0;
            r_data     <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_dbz <= 1'b0;
                        if (!op_i[1]) begin
                            r_data <= {{WIDTH{1'b0}}, (op_i[0] ? w_diff : w_sum)};
                            r_ovf  <= op_i[0] ? w_sub_ovf : w_add_ovf;
                        end else begin
                            r_data     <= '0;
                            r_ovf      <= 1'b0;
                            r_is_div   <= op_i[0];
                            r_mag_b    <= w_mag_b;
                            r_a_raw    <= a_i;
                            r_neg_res  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                            r_neg_a    <= a_i[WIDTH-1];
                            r_dbz_pend <= op_i[0] && (b_i == '0);
                            r_ovf_pend <= op_i[0] && (a_i == c_min_w) && (b_i == c_ones_w);
                            r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    // Divide-by-zero idles the datapath but keeps the cycle count.
                    if (!(r_is_div && r_dbz_pend)) begin
                        r_acc <= w_step_next;
                    end
                    if (w_last) begin
                        r_data <= w_final_data;
                        r_ovf  <= r_is_div && r_ovf_pend;
                        r_dbz  <= r_is_div && r_dbz_pend;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed and randomised scoreboard bench for seq_alu (WIDTH=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int c_width = 6;

    logic               r_clk = 1'b0;
    logic               r_rst;
    logic               r_in_valid;
    logic [5:0]         r_a;
    logic [5:0]         r_b;
    logic [1:0]         r_op;
    logic               r_out_ready;
    logic               w_in_ready;
    logic               w_out_valid;
    logic [11:0]        w_data;
    logic               w_ovf;
    logic               w_dbz;
    logic               w_busy;

    int                 checks   = 0;
    int                 failures = 0;
    logic [13:0]        sb_q[$];

    always #5 r_clk = ~r_clk;

    seq_alu #(.WIDTH(c_width)) dut (
        .clk_i       (r_clk),
        .rst_i       (r_rst),
        .in_valid_i  (r_in_valid),
        .in_ready_o  (w_in_ready),
        .a_i         (r_a),
        .b_i         (r_b),
        .op_i        (r_op),
        .out_valid_o (w_out_valid),
        .out_ready_i (r_out_ready),
        .data_o      (w_data),
        .ovf_o       (w_ovf),
        .dbz_o       (w_dbz),
        .busy_o      (w_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {data, ovf, dbz} built from plain integer arithmetic.
    function automatic logic [13:0] model(input logic signed [5:0] a, input logic signed [5:0] b,
                                          input logic [1:0] op);
        int          sa;
        int          sb;
        int          r;
        int          q;
        int          rm;
        logic [31:0] rv;
        logic [31:0] qv;
        logic [31:0] rmv;
        logic [11:0] d;
        logic        o;
        logic        z;
        sa = a;
        sb = b;
        o  = 1'b0;
        z  = 1'b0;
        d  = '0;
        case (op)
            2'b00, 2'b01: begin
                r  = (op == 2'b00) ? sa + sb : sa - sb;
                rv = r;
                d  = {6'b0, rv[5:0]};
                o  = (r > 31) || (r < -32);
            end
            2'b10: begin
                rv = sa * sb;
                d  = rv[11:0];
            end
            default: begin
                if (sb == 0) begin
                    d = {a, 6'h3F};
                    z = 1'b1;
                end else if (sa == -32 && sb == -1) begin
                    d = 12'h020;
                    o = 1'b1;
                end else begin
                    q   = sa / sb;
                    rm  = sa % sb;
                    qv  = q;
                    rmv = rm;
                    d   = {rmv[5:0], qv[5:0]};
                end
            end
        endcase
        return {d, o, z};
    endfunction

    task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                        input logic [13:0] exp, input bit push, input bit noise);
        int n;
        n = 0;
        while (w_in_ready !== 1'b1 && n < 50) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        check("send_ready", {31'b0, w_in_ready}, 32'd1);
        r_in_valid = 1'b1;
        r_a        = a;
        r_b        = b;
        r_op       = op;
        if (push) sb_q.push_back(exp);
        @(posedge r_clk);
        #1;
        r_in_valid = noise;
        if (noise) begin
            r_a  = 6'($urandom);
            r_b  = 6'($urandom);
            r_op = 2'($urandom);
        end
    endtask

    task automatic recv(input int exp_lat, input int stall);
        int          lat;
        logic [11:0] held;
        logic [13:0] e;
        lat = 1;
        while (w_out_valid !== 1'b1 && lat < 40) begin
            check("busy_calc", {31'b0, w_busy}, 32'd1);
            @(posedge r_clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        held = w_data;
        for (int i = 0; i < stall; i++) begin
            check("hold_ready", {31'b0, w_in_ready}, 32'd0);
            @(posedge r_clk);
            #1;
            check("hold_data", {20'b0, w_data}, {20'b0, held});
            check("hold_valid", {31'b0, w_out_valid}, 32'd1);
        end
        check("sb_size", sb_q.size(), 32'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 14'h3FFF;
        check("data", {20'b0, w_data}, {20'b0, e[13:2]});
        check("ovf", {31'b0, w_ovf}, {31'b0, e[1]});
        check("dbz", {31'b0, w_dbz}, {31'b0, e[0]});
        r_in_valid  = 1'b0;
        r_out_ready = 1'b1;
        @(posedge r_clk);
        #1;
        r_out_ready = 1'b0;
        check("retire_valid", {31'b0, w_out_valid}, 32'd0);
        check("retire_ready", {31'b0, w_in_ready}, 32'd1);
    endtask

    initial begin
        logic [5:0] ra;
        logic [5:0] rb;
        logic [1:0] rop;

        r_rst       = 1'b1;
        r_in_valid  = 1'b0;
        r_a         = '0;
        r_b         = '0;
        r_op        = '0;
        r_out_ready = 1'b0;
        repeat (3) @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        check("rst_in_ready", {31'b0, w_in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, w_out_valid}, 32'd0);
        check("rst_data", {20'b0, w_data}, 32'd0);
        check("rst_flags", {30'b0, w_ovf, w_dbz}, 32'd0);
        check("rst_busy", {31'b0, w_busy}, 32'd0);

        send(6'd31, 6'd1, 2'b00, {12'h020, 1'b1, 1'b0}, 1'b1, 1'b0);
        recv(1, 0);
        send(6'h20, 6'h20, 2'b10, {12'h400, 1'b0, 1'b0}, 1'b1, 1'b1);
        recv(7, 0);
        send(6'h39, 6'd2, 2'b11, {12'hFFD, 1'b0, 1'b0}, 1'b1, 1'b1);
        recv(7, 0);
        send(6'h20, 6'h3F, 2'b11, {12'h020, 1'b1, 1'b0}, 1'b1, 1'b0);
        recv(7, 0);
        send(6'd5, 6'd0, 2'b11, {12'h17F, 1'b0, 1'b1}, 1'b1, 1'b0);
        recv(7, 0);
        send(6'd3, 6'd5, 2'b01, {12'h03E, 1'b0, 1'b0}, 1'b1, 1'b0);
        recv(1, 10);
        send(6'h20, 6'h3F, 2'b00, model(6'h20, 6'h3F, 2'b00), 1'b1, 1'b0);
        recv(1, 1);
        send(6'h20, 6'd1, 2'b01, model(6'h20, 6'd1, 2'b01), 1'b1, 1'b0);
        recv(1, 0);

        // Abort a multiply three cycles in; nothing may come out of it.
        send(6'd7, 6'd9, 2'b10, 14'h0, 1'b0, 1'b0);
        @(posedge r_clk);
        #1;
        @(posedge r_clk);
        #1;
        r_rst = 1'b1;
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        check("abort_valid", {31'b0, w_out_valid}, 32'd0);
        check("abort_data", {20'b0, w_data}, 32'd0);
        check("abort_ready", {31'b0, w_in_ready}, 32'd1);
        check("abort_busy", {31'b0, w_busy}, 32'd0);
        send(6'd1, 6'd2, 2'b00, {12'h003, 1'b0, 1'b0}, 1'b1, 1'b0);
        recv(1, 0);

        for (int i = 0; i < 16; i++) begin
            ra  = 6'($urandom);
            rb  = (i == 5) ? 6'd0 : 6'($urandom);
            rop = (i == 5) ? 2'b11 : 2'(i);
            send(ra, rb, rop, model(ra, rb, rop), 1'b1, (i % 2) == 1);
            recv(rop[1] ? 7 : 1, i % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
